// File: rtl/psum_accumulator.sv
// Output-pixel partial-sum accumulator: bias + N partial sums, round-half-up
// requantization by cfg_shift, saturation to int8. Define PSUM_ACC_RELU_EN to clamp negatives to 0.
module psum_accumulator (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         cfg_num_psum,
    input  logic [4:0]         cfg_shift,
    input  logic signed [15:0] bias,
    input  logic               psum_valid,
    input  logic signed [24:0] p_sum,
    output logic               psum_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [7:0]  out_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACC, QUANT, OUT} state_t;

    state_t             state, state_nxt;
    logic signed [33:0] acc;
    logic [7:0]         count;
    logic [7:0]         n_lat;
    logic [4:0]         shift_lat;
    logic               last_psum;

    logic signed [34:0] rnd, sum, r;
    logic signed [7:0]  q;

    assign last_psum  = (count == n_lat - 8'd1);
    assign psum_ready = (state == ACC);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (psum_valid && last_psum) state_nxt = QUANT;
            QUANT:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Round half up before the arithmetic shift; one extra bit keeps the add from overflowing.
    always_comb begin
        rnd = '0;
        if (shift_lat != 5'd0) rnd = 35'sd1 <<< (shift_lat - 5'd1);
        sum = {acc[33], acc} + rnd;
        r   = sum >>> shift_lat;
`ifdef PSUM_ACC_RELU_EN
        if (r < 35'sd0)        q = 8'sd0;
        else if (r > 35'sd127) q = 8'sd127;
        else                   q = r[7:0];
`else
        if (r > 35'sd127)       q = 8'sd127;
        else if (r < -35'sd128) q = -8'sd128;
        else                    q = r[7:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            n_lat     <= '0;
            shift_lat <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_lat     <= (cfg_num_psum == 8'd0) ? 8'd1 : cfg_num_psum;
                    shift_lat <= cfg_shift;
                    acc       <= {{18{bias[15]}}, bias};
                    count     <= '0;
                end
                ACC: if (psum_valid) begin
                    acc   <= acc + {{9{p_sum[24]}}, p_sum};
                    count <= count + 8'd1;
                end
                QUANT: begin
                    out_data  <= q;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: hand-computed vectors, immediate assertions per check.
module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         cfg_num_psum;
    logic [4:0]         cfg_shift;
    logic signed [15:0] bias;
    logic               psum_valid;
    logic signed [24:0] p_sum;
    logic               psum_ready;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               busy;

    int checks = 0;
    int errors = 0;

    psum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_psum(cfg_num_psum),
        .cfg_shift(cfg_shift), .bias(bias), .psum_valid(psum_valid), .p_sum(p_sum),
        .psum_ready(psum_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, input int sh, input int b);
        start        = 1'b1;
        cfg_num_psum = 8'(n);
        cfg_shift    = 5'(sh);
        bias         = 16'(b);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        psum_valid = 1'b1;
        p_sum      = 25'(v);
        tick();
        psum_valid = 1'b0;
    endtask

    // Last p_sum was just accepted: out_valid must stay low one cycle, then rise.
    task automatic expect_result(input string tag, input int exp);
        chk({tag, "_lat_lo"}, int'(out_valid), 0);
        tick();
        chk({tag, "_lat_hi"}, int'(out_valid), 1);
        chk({tag, "_data"}, int'(out_data), exp);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("accept_valid", int'(out_valid), 0);
        chk("accept_busy", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_num_psum = '0; cfg_shift = '0; bias = '0;
        psum_valid = 1'b0; p_sum = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_psum_ready", int'(psum_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 10+100+200-50+40 = 300; (300+2)>>2 = 75; config wiggled mid-run must not matter
        do_start(4, 2, 10);
        chk("acc_ready", int'(psum_ready), 1);
        chk("acc_busy", int'(busy), 1);
        cfg_num_psum = 8'd9; cfg_shift = 5'd7; bias = -16'sd999;
        feed(100);
        tick();                          // idle gap: psum_valid low holds state
        feed(200); feed(-50);
        chk("acc_not_done", int'(psum_ready), 1);
        feed(40);
        chk("quant_ready_lo", int'(psum_ready), 0);
        expect_result("r029", 75);

        // Hold out_ready low 5 cycles with start pulsed: output stable, start ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), 75);
            chk("hold_busy", int'(busy), 1);
        end
        start = 1'b0;
        accept();

        // -800+4 = -796 >>> 3 = -100 (ReLU build: 0)
        do_start(2, 3, 0);
        feed(-500); feed(-300);
`ifdef PSUM_ACC_RELU_EN
        expect_result("r030", 0);
`else
        expect_result("r030", -100);
`endif
        accept();

        do_start(1, 0, 0);
        feed(1000000);
        expect_result("r031_pos", 127);
        accept();

        // 255*(-2^24) - 32768 fits in 34 bits; must saturate low, not wrap
        do_start(255, 0, -32768);
        for (int i = 0; i < 254; i++) feed(-16777216);
        chk("r031_still_acc", int'(psum_ready), 1);
        feed(-16777216);
`ifdef PSUM_ACC_RELU_EN
        expect_result("r031_neg", 0);
`else
        expect_result("r031_neg", -128);
`endif
        accept();

        // Reset mid-accumulation: outputs clear at once, no stale acc afterwards
        do_start(4, 0, 0);
        feed(300); feed(400);
        #2 rst_n = 1'b0;
        #1;
        chk("r033_busy", int'(busy), 0);
        chk("r033_valid", int'(out_valid), 0);
        chk("r033_data", int'(out_data), 0);
        chk("r033_ready", int'(psum_ready), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("r033_no_output", int'(out_valid), 0);
        do_start(1, 0, 0);
        feed(8);
        expect_result("r033", 8);

        // start held through the OUT-completing edge is honoured only on the next edge
        start = 1'b1; cfg_num_psum = 8'd0; cfg_shift = 5'd0; bias = 16'sd0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("r022_idle", int'(busy), 0);
        start = 1'b0;
        // psum_valid in IDLE must not touch acc
        psum_valid = 1'b1; p_sum = 25'sd1000;
        tick(); tick();
        psum_valid = 1'b0;
        chk("r023_idle", int'(busy), 0);

        // cfg_num_psum=0 behaves as N=1
        do_start(0, 0, 0);
        feed(5);
        expect_result("r034", 5);
        accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, begins one output-pixel accumulation; honoured only in IDLE.
REQ-004 SHALL have port cfg_num_psum, input, 8, partial sums per output; sampled at accepted start; 0 treated as 1.
REQ-005 SHALL have port cfg_shift, input, 5, requantization right-shift (0..31); sampled at accepted start.
REQ-006 SHALL have port bias, input, 16 signed, output bias; sampled at accepted start.
REQ-007 SHALL have port psum_valid, input, 1, p_sum carries a valid partial sum from the PE stage.
REQ-008 SHALL have port p_sum, input, 25 signed, partial sum from the PE stage.
REQ-009 SHALL have port psum_ready, output, 1, high only in ACC.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-012 SHALL have port out_data, output, 8 signed, requantized result.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, QUANT, OUT.
REQ-015 In IDLE with start=1: latch config, set acc = sign-extended bias, set count = 0, go to ACC.
REQ-016 acc SHALL be 34-bit signed; p_sum and bias SHALL be sign-extended; no overflow is possible for N <= 255.
REQ-017 In ACC, on psum_valid=1: acc += p_sum, count += 1; when count reaches N-1, go to QUANT on the same edge.
REQ-018 In ACC, psum_valid=0 SHALL hold acc and count; there is no timeout.
REQ-019 In QUANT, compute r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (arithmetic), saturate r to [-128,127], register the result into out_data, set out_valid=1, go to OUT.
REQ-020 In OUT, out_valid and out_data SHALL stay stable until out_ready=1; on that edge clear out_valid and go to IDLE.
REQ-021 Latency SHALL be 2 cycles from the last accepted p_sum to out_valid=1.
REQ-022 start outside IDLE SHALL be ignored; start in the cycle OUT completes SHALL be ignored, and is honoured only from the following IDLE cycle.
REQ-023 psum_valid outside ACC SHALL be ignored and SHALL NOT modify acc.
REQ-024 Config input changes after start SHALL NOT affect the accumulation in progress.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, acc=0, count=0, out_data=0, out_valid=0, psum_ready=0, busy=0, latched config=0.
REQ-026 Reset during ACC, QUANT or OUT SHALL discard the accumulation; no output is produced after release.

Configuration
REQ-027 With macro PSUM_ACC_RELU_EN defined, QUANT SHALL output 0 for r < 0 and saturate positive values to 127.
REQ-028 Without PSUM_ACC_RELU_EN, QUANT SHALL apply signed saturation to [-128,127] only.

Verification
REQ-029 N=4, bias=10, shift=2, p_sum 100,200,-50,40 -> acc=300, out_data=75, out_valid 2 cycles after the 4th p_sum.
REQ-030 N=2, bias=0, shift=3, p_sum -500,-300 -> out_data=-100 without the macro; out_data=0 with PSUM_ACC_RELU_EN.
REQ-031 N=1, bias=0, shift=0, p_sum=1000000 -> out_data=127; N=255, bias=-32768, p_sum=-16777216 every cycle -> out_data=-128, no wraparound.
REQ-032 Result 75 with out_ready held low 5 cycles -> out_data stays 75 and out_valid stays 1; start pulsed during OUT is ignored (busy stays 1).
REQ-033 rst_n low after 2 of 4 p_sums -> all outputs 0 immediately; after release, a new start with N=1, p_sum=8, shift=0 gives out_data=8 (no stale acc).
REQ-034 cfg_num_psum=0, p_sum=5, bias=0, shift=0 -> treated as N=1; out_data=5 after a single accepted p_sum.
